// File: rtl/instr_mem_responder.sv
// Instruction fetch responder: req/gnt accept, rvalid/rdata after WAIT_CYCLES wait states.
// Define IMEM_ERR_EN to flag misaligned/out-of-range fetches and drop out-of-range writes.
module instr_mem_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h10074,
    parameter int                    WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  accept;
    logic                  enter_resp;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [ADDR_WIDTH-1:0] rd_addr, rd_off, wr_off;
    logic [IDX_W-1:0]      rd_idx, wr_idx;
    logic                  rd_err, wr_ok;

    assign gnt_o  = (state_q == S_IDLE) || (state_q == S_RESP);
    assign accept = req_i && gnt_o;

    // With zero wait states the read happens on the accept edge itself
    assign rd_addr = accept ? addr_i : addr_q;
    assign rd_off  = rd_addr - BASE_ADDR;
    assign wr_off  = wr_addr_i - BASE_ADDR;
    assign rd_idx  = rd_off[IDX_W+1:2];
    assign wr_idx  = wr_off[IDX_W+1:2];

`ifdef IMEM_ERR_EN
    // Addresses below BASE_ADDR wrap to large offsets, so one upper-bit test covers both ends
    assign rd_err = (rd_addr[1:0] != 2'b00)
                 || (rd_off[ADDR_WIDTH-1:IDX_W+2] != '0);
    assign wr_ok  = (wr_off[ADDR_WIDTH-1:IDX_W+2] == '0);

    logic unused_bits;
    assign unused_bits = ^{rd_off[1:0], wr_off[1:0]};
`else
    assign rd_err = 1'b0;
    assign wr_ok  = 1'b1;

    logic unused_bits;
    assign unused_bits = ^{rd_off[1:0], rd_off[ADDR_WIDTH-1:IDX_W+2],
                           wr_off[1:0], wr_off[ADDR_WIDTH-1:IDX_W+2]};
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= 1'b0;
            if (accept) begin
                addr_q <= addr_i;
            end
            if (enter_resp) begin
                err_q   <= rd_err;
                rdata_q <= rd_err ? NOP : mem[rd_idx];
            end
        end
    end

    // Storage is never reset; the preload port works in every FSM state
    always_ff @(posedge clk) begin
        if (wr_en_i && wr_ok) begin
            mem[wr_idx] <= wr_data_i;
        end
    end

    assign rvalid_o = (state_q == S_RESP);
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized scoreboard bench: three responders (0/1/3 wait states) share reset and preload port.
// Expected responses come from a transaction-level model of pending fetches and a word array.
module tb_instr_mem_responder;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0001_0074;
    localparam int          NLANE = 3;
    localparam int          NCYC  = 2500;

`ifdef IMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        bit [31:0] d;
        bit        e;
        int        due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    bit          run = 1'b0;

    int errors = 0;
    int checks = 0;
    int ecnt = 0;
    int resp_cnt [NLANE];

    bit [31:0] mem_m [DEPTH];

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    function automatic bit in_range(bit [31:0] a);
        longint unsigned la, lo, hi;
        la = a;
        lo = BASE;
        hi = lo + 4 * DEPTH;
        return (la >= lo) && (la < hi);
    endfunction

    function automatic int widx(bit [31:0] a);
        bit [31:0] off;
        off = a - BASE;
        return int'((off >> 2) % DEPTH);
    endfunction

    function automatic exp_t model_read(bit [31:0] a, int due);
        exp_t x;
        x.due = due;
        if (ERR_EN && (a[1:0] != 2'b00 || !in_range(a))) begin
            x.e = 1'b1;
            x.d = 32'h0000_0013;
        end else begin
            x.e = 1'b0;
            x.d = mem_m[widx(a)];
        end
        return x;
    endfunction

    function automatic bit [31:0] rand_addr();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k < 5) return BASE + 4 * $urandom_range(0, 7);
        if (k < 8) return BASE + 4 * $urandom_range(0, DEPTH - 1);
        case ($urandom_range(0, 3))
            0:       return BASE + 4 * $urandom_range(0, DEPTH - 1)
                          + $urandom_range(1, 3);
            1:       return BASE - 4 * $urandom_range(1, 64);
            2:       return BASE + 4 * DEPTH + 4 * $urandom_range(0, DEPTH - 1);
            default: return $urandom();
        endcase
    endfunction

    // Word-array model; non-blocking so same-edge reads see the old word
    always @(posedge clk) begin
        if (wr_en && (!ERR_EN || in_range(wr_addr))) begin
            mem_m[widx(wr_addr)] <= wr_data;
        end
    end

    for (genvar g = 0; g < NLANE; g++) begin : lane
        localparam int WC = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

        logic        req = 1'b0;
        logic [31:0] addr = BASE;
        logic        gnt, rvalid, err;
        logic [31:0] rdata;

        exp_t      q [$];
        bit        pend = 1'b0;
        bit [31:0] paddr = '0;
        int        due = 0;
        bit        gnt_exp = 1'b1;

        instr_mem_responder #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .DEPTH_WORDS(DEPTH),
            .BASE_ADDR  (BASE),
            .WAIT_CYCLES(WC)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_i    (req),
            .addr_i   (addr),
            .gnt_o    (gnt),
            .rvalid_o (rvalid),
            .rdata_o  (rdata),
            .err_o    (err),
            .wr_en_i  (wr_en),
            .wr_addr_i(wr_addr),
            .wr_data_i(wr_data)
        );

        always @(negedge clk) begin
            if (run) begin
                req  = ($urandom_range(0, 99) < 60);
                addr = rand_addr();
            end else begin
                req = 1'b0;
            end
        end

        // One outstanding fetch; its response is due WC edges after accept
        always @(posedge clk) begin
            int e;
            bit free;
            e = ecnt + 1;
            if (!rst_n) begin
                pend    = 1'b0;
                gnt_exp = 1'b1;
            end else begin
                free = !pend;
                if (pend && due == e) begin
                    q.push_back(model_read(paddr, e));
                    pend = 1'b0;
                end
                if (req && free) begin
                    if (WC == 0) begin
                        q.push_back(model_read(addr, e));
                    end else begin
                        pend  = 1'b1;
                        paddr = addr;
                        due   = e + WC;
                    end
                end
                gnt_exp = !pend;
            end
        end

        always @(negedge clk) begin
            exp_t x;
            if (ecnt >= 1) begin
                checks++;
                if (gnt !== gnt_exp) begin
                    errors++;
                    $display("FAIL lane%0d gnt edge=%0d got=%b exp=%b",
                             g, ecnt, gnt, gnt_exp);
                end
                checks++;
                if (rvalid === 1'b1) begin
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL lane%0d spurious_rvalid edge=%0d got=1 exp=0",
                                 g, ecnt);
                    end else begin
                        x = q.pop_front();
                        resp_cnt[g]++;
                        if (x.due != ecnt || rdata !== x.d || err !== x.e) begin
                            errors++;
                            $display({"FAIL lane%0d resp edge=%0d exp_edge=%0d ",
                                      "got data=%h err=%b exp data=%h err=%b"},
                                     g, ecnt, x.due, rdata, err, x.d, x.e);
                        end
                    end
                end else begin
                    if (err !== 1'b0 || (q.size() > 0 && q[0].due <= ecnt)) begin
                        errors++;
                        $display("FAIL lane%0d idle edge=%0d got rvalid=%b err=%b exp rvalid=%b err=0",
                                 g, ecnt, rvalid, err, q.size() > 0);
                        if (q.size() > 0 && q[0].due <= ecnt) void'(q.pop_front());
                    end
                end
            end
        end

        initial begin
            repeat (2) @(negedge clk);
            checks++;
            if (gnt !== 1'b1 || rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
                errors++;
                $display("FAIL lane%0d reset got gnt=%b rvalid=%b err=%b rdata=%h exp 1 0 0 0",
                         g, gnt, rvalid, err, rdata);
            end
        end
    end

    initial begin
        for (int i = 0; i < NLANE; i++) resp_cnt[i] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = BASE + 4 * i;
            wr_data = $urandom();
        end
        @(negedge clk);
        wr_en = 1'b0;

        run = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 149) != 0);
            wr_en = rst_n && ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 9) < 6)
                wr_addr = BASE + 4 * $urandom_range(0, 7);
            else
                wr_addr = BASE + 4 * $urandom_range(0, 2 * DEPTH - 1);
            wr_data = $urandom();
        end

        @(negedge clk);
        run   = 1'b0;
        rst_n = 1'b1;
        wr_en = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < NLANE; i++) begin
            checks++;
            if (resp_cnt[i] < 100) begin
                errors++;
                $display("FAIL lane%0d resp_count got=%0d exp>=100", i, resp_cnt[i]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
